// File: rtl/pool_pkg.sv
// Shared constants and reduction helpers for the 2x2 pooling engine.
// Helpers work on a wide container; callers extend operands (sign or zero) first.
`default_nettype none
package pool_pkg;
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;
  // Wide enough for DATA_W up to 32 plus the two growth bits of the 4-pixel sum.
  localparam int EXT_W = 34;

  typedef logic [EXT_W-1:0] ext_t;

  function automatic ext_t pool_max(input ext_t a, input ext_t b, input logic sgn);
    logic a_gt;
    a_gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
    return a_gt ? a : b;
  endfunction

  function automatic ext_t pool_sum(input ext_t a, input ext_t b);
    return a + b;
  endfunction
endpackage
`default_nettype wire

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer holding top-row partials between row pairs.
// One write port, one registered read port; read data holds until the next read.
`default_nettype none
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/pool2x2_stream.sv
// 2x2 / stride-2 max or average pooling over a raster-order pixel stream.
// Top-row pair partials are parked in a line buffer and merged on the odd row.
`default_nettype none
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              out_last
);
  localparam int CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DEPTH   = IMG_W / 2;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW      = DATA_W + 1;
  localparam int COL_END = 2 * (IMG_W / 2) - 1;
  localparam int ROW_END = 2 * (IMG_H / 2) - 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] held;
  logic              mode_q;
  logic [PW-1:0]     p_rd;
  logic              col_last, row_last, active, beat;
  logic              wr_en, rd_en, win, win_last;
  ext_t              pair, sum2, comb;

  function automatic ext_t ext_px(input logic [DATA_W-1:0] x);
    if (SIGNED) return {{(EXT_W-DATA_W){x[DATA_W-1]}}, x};
    else        return {{(EXT_W-DATA_W){1'b0}}, x};
  endfunction

  function automatic ext_t ext_pp(input logic [PW-1:0] x);
    if (SIGNED) return {{(EXT_W-PW){x[PW-1]}}, x};
    else        return {{(EXT_W-PW){1'b0}}, x};
  endfunction

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  // An odd trailing column/row is still counted but never joins a window.
  assign active   = (col <= CW'(COL_END)) && (row <= RW'(ROW_END));
  assign beat     = in_valid && !clr;
  assign wr_en    = beat && active && !row[0] &&  col[0];
  assign rd_en    = beat && active &&  row[0] && !col[0];
  assign win      = beat && active &&  row[0] &&  col[0];
  assign win_last = (row == RW'(ROW_END)) && (col == CW'(COL_END));

  always_comb begin
    pair = (mode_q == POOL_AVG) ? pool_sum(ext_px(held), ext_px(data_in))
                                : pool_max(ext_px(held), ext_px(data_in), SIGNED);
    sum2 = pool_sum(ext_pp(p_rd), pair);
    comb = pool_max(ext_pp(p_rd), pair, SIGNED);
    if (mode_q == POOL_AVG) begin
      if (SIGNED) comb = ext_t'($signed(sum2) >>> 2);
      else        comb = sum2 >> 2;
    end
  end

  pool_line_buf #(
    .DEPTH (DEPTH),
    .WIDTH (PW),
    .ADDR_W(AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(AW'(col >> 1)),
    .wdata(PW'(pair)),
    .re   (rd_en),
    .raddr(AW'(col >> 1)),
    .rdata(p_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      held      <= '0;
      mode_q    <= POOL_MAX;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= win;
      out_last  <= win && win_last;
      if (win) data_out <= DATA_W'(comb);
      if (clr) begin
        col  <= '0;
        row  <= '0;
        held <= '0;
      end else if (in_valid) begin
        if (col == '0 && row == '0) mode_q <= mode;
        if (!col[0]) held <= data_in;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire
